// File: rtl/hi_lo_muldiv_unit.sv
// Iterative multiply/divide engine that owns the architectural HI/LO registers.
// Uses shift-add multiply and restoring divide, one bit per cycle, with a final sign-fix cycle.
module hi_lo_muldiv_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 5,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MUL  = 5'h18,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MULU = 5'h19,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_DIV  = 5'h1a,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_DIVU = 5'h1b,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MTHI = 5'h1c,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MTLO = 5'h1d
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    req,
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   rs,
  input  logic [DATA_WIDTH-1:0]   rt,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo,
  output logic                    busy,
  output logic                    done
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    mcand;
  logic [W-1:0]    rem;
  logic            neg_res;
  logic            neg_rem;
  logic            is_div_op;

  logic            is_mul;
  logic            is_div;
  logic            is_signed;
  logic            rs_neg;
  logic            rt_neg;
  logic [W-1:0]    rs_mag;
  logic [W-1:0]    rt_mag;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic [W+1:0]    div_diff;
  logic [2*W-1:0]  prod_neg;
  logic [W-1:0]    quo_neg;
  logic [W-1:0]    rem_neg;

  // prod doubles as the multiply accumulator and, in its low half, the dividend/quotient shifter;
  // div_shift is the partial remainder for the current restoring step.
  always_comb begin
    is_mul    = (op == ALU_OP_MUL) || (op == ALU_OP_MULU);
    is_div    = (op == ALU_OP_DIV) || (op == ALU_OP_DIVU);
    is_signed = (op == ALU_OP_MUL) || (op == ALU_OP_DIV);
    rs_neg    = is_signed & rs[W-1];
    rt_neg    = is_signed & rt[W-1];
    rs_mag    = rs_neg ? -rs : rs;
    rt_mag    = rt_neg ? -rt : rt;
    mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    div_shift = {rem, prod[W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mcand};
    prod_neg  = -prod;
    quo_neg   = -prod[W-1:0];
    rem_neg   = -rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      prod      <= '0;
      mcand     <= '0;
      rem       <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      is_div_op <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en && req && !flush && (is_mul || is_div)) begin
            busy      <= 1'b1;
            cnt       <= '0;
            rem       <= '0;
            neg_res   <= rs_neg ^ rt_neg;
            neg_rem   <= rs_neg;
            is_div_op <= is_div;
            if (is_mul) begin
              prod  <= {{W{1'b0}}, rt_mag};
              mcand <= rs_mag;
              state <= MUL;
            end else if (rt == '0) begin
              // Divide by zero: preload the fixed result so FIX emits lo=all-ones, hi=rs.
              prod    <= {{W{1'b0}}, {W{1'b1}}};
              rem     <= rs;
              mcand   <= '0;
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              state   <= FIX;
            end else begin
              prod  <= {{W{1'b0}}, rs_mag};
              mcand <= rt_mag;
              state <= DIV;
            end
          end else if (en && op == ALU_OP_MTHI) begin
            hi <= rs;
          end else if (en && op == ALU_OP_MTLO) begin
            lo <= rs;
          end
        end
        MUL: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            prod <= {mul_sum, prod[W-1:1]};
            cnt  <= cnt + CW'(1);
            if (cnt == LAST_STEP) state <= FIX;
          end
        end
        DIV: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem            <= div_diff[W+1] ? div_shift[W-1:0] : div_diff[W-1:0];
            prod[W-1:0]    <= {prod[W-2:0], ~div_diff[W+1]};
            cnt            <= cnt + CW'(1);
            if (cnt == LAST_STEP) state <= FIX;
          end
        end
        FIX: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (is_div_op) begin
              lo <= neg_res ? quo_neg : prod[W-1:0];
              hi <= neg_rem ? rem_neg : rem;
            end else begin
              {hi, lo} <= neg_res ? prod_neg : prod;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Randomised self-checking bench for hi_lo_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_hi_lo_muldiv_unit;

  localparam logic [4:0] OP_NONE = 5'h00;
  localparam logic [4:0] OP_MUL  = 5'h18;
  localparam logic [4:0] OP_MULU = 5'h19;
  localparam logic [4:0] OP_DIV  = 5'h1a;
  localparam logic [4:0] OP_DIVU = 5'h1b;
  localparam logic [4:0] OP_MTHI = 5'h1c;
  localparam logic [4:0] OP_MTLO = 5'h1d;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        req;
  logic [4:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  hi_lo_muldiv_unit #(
    .DATA_WIDTH(32), .ALU_OP_WIDTH(5),
    .ALU_OP_MUL(OP_MUL), .ALU_OP_MULU(OP_MULU), .ALU_OP_DIV(OP_DIV),
    .ALU_OP_DIVU(OP_DIVU), .ALU_OP_MTHI(OP_MTHI), .ALU_OP_MTLO(OP_MTLO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Architectural result of one muldiv op, plus how many clocks until done pulses.
  function automatic void model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output int lat);
    longint          sa, sb, sq, sr;
    logic [63:0]     p, q64, r64;
    lat = 33;
    h = '0;
    l = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MUL: begin
        sq = sa * sb;
        p = sq;
        h = p[63:32];
        l = p[31:0];
      end
      OP_MULU: begin
        p = {32'd0, a} * {32'd0, b};
        h = p[63:32];
        l = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          lat = 1;
          l = 32'hFFFF_FFFF;
          h = a;
        end else if (o == OP_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          q64 = sq;
          r64 = sr;
          l = q64[31:0];
          h = r64[31:0];
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  // Issues one muldiv request and follows it; negative *_at values disable flush/extra-req/reset injection.
  task automatic applyStimulus(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                               input int flush_at, input int req_at, input int rst_at);
    logic [31:0] nh, nl;
    int lat, busy_cnt, done_at;
    model(o, a, b, nh, nl, lat);
    en = 1'b1; req = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    req = 1'b0; op = OP_NONE; rs = $urandom; rt = $urandom;
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    busy_cnt = 0;
    done_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        done_at = k;
        break;
      end
      if (busy) busy_cnt++;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == req_at) begin
        req = 1'b1;
        op = (k % 2 == 1) ? OP_MTHI : OP_MULU;
        rs = $urandom;
        rt = $urandom;
      end
      if (k == flush_at) flush = 1'b1;
      @(negedge clk);
      req = 1'b0; op = OP_NONE; flush = 1'b0;
      if (k == flush_at) begin
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_done", 64'(done), 64'd0);
        checkOutput("flush_hi", 64'(hi), 64'(exp_hi));
        checkOutput("flush_lo", 64'(lo), 64'(exp_lo));
        @(negedge clk);
        checkOutput("flush_no_late_done", 64'(done), 64'd0);
        return;
      end
    end
    checkOutput("latency", 64'(done_at), 64'(lat));
    checkOutput("busy_cycles", 64'(busy_cnt), 64'(lat));
    checkOutput("busy_at_done", 64'(busy), 64'd0);
    exp_hi = nh;
    exp_lo = nl;
    checkOutput("hi", 64'(hi), 64'(exp_hi));
    checkOutput("lo", 64'(lo), 64'(exp_lo));
    @(negedge clk);
    checkOutput("done_single_pulse", 64'(done), 64'd0);
  endtask

  task automatic applyMove(input logic [4:0] o, input logic [31:0] a);
    en = 1'b1; op = o; rs = a;
    @(negedge clk);
    op = OP_NONE; rs = $urandom;
    if (o == OP_MTHI) exp_hi = a;
    else exp_lo = a;
    checkOutput("move_busy", 64'(busy), 64'd0);
    checkOutput("move_hi", 64'(hi), 64'(exp_hi));
    checkOutput("move_lo", 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    vectors = 0;
    miscompares = 0;
    exp_hi = '0;
    exp_lo = '0;
    clk = 1'b0; rst_n = 1'b0; en = 1'b0; req = 1'b0; flush = 1'b0;
    op = OP_NONE; rs = '0; rt = '0;
    repeat (2) @(negedge clk);
    checkOutput("init_hi", 64'(hi), 64'd0);
    checkOutput("init_lo", 64'(lo), 64'd0);
    checkOutput("init_busy", 64'(busy), 64'd0);
    checkOutput("init_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(OP_MUL, 32'hFFFF_FFFD, 32'd7, -1, -1, -1);
    applyStimulus(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 12, -1);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, 7, -1);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
    applyStimulus(OP_DIVU, 32'd100, 32'd0, -1, -1, -1);
    applyMove(OP_MTLO, 32'd5);
    applyStimulus(OP_MUL, 32'd6, 32'd7, 10, -1, -1);
    applyStimulus(OP_MUL, 32'd6, 32'd7, -1, -1, -1);

    // flush and req together in IDLE: the request must be dropped
    en = 1'b1; req = 1'b1; flush = 1'b1; op = OP_MUL; rs = 32'd3; rt = 32'd3;
    @(negedge clk);
    req = 1'b0; flush = 1'b0; op = OP_NONE;
    checkOutput("flush_req_idle_busy", 64'(busy), 64'd0);

    applyStimulus(OP_DIVU, $urandom, 32'd13, -1, -1, 20);

    en = 1'b0; req = 1'b1; op = OP_MUL; rs = 32'd9; rt = 32'd9;
    repeat (3) begin
      @(negedge clk);
      checkOutput("disabled_busy", 64'(busy), 64'd0);
      checkOutput("disabled_done", 64'(done), 64'd0);
    end
    req = 1'b0; op = OP_NONE;
    checkOutput("disabled_hi", 64'(hi), 64'(exp_hi));
    checkOutput("disabled_lo", 64'(lo), 64'(exp_lo));

    for (int i = 0; i < 30; i++) begin
      rop = OP_MUL + 5'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
      if ($urandom_range(0, 7) == 0) applyMove(($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, $urandom);
      applyStimulus(rop, ra, rb,
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 32)) : -1,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
